multi_core_miner_ctrl: RTL and testbench
========================================

MULTI_CORE_MINER_CTRL -- requirements
Module: multi_core_miner_ctrl

Interface
REQ-001 Parameter NUM_CORES, default 4, number of external SHA cores; legal values 1, 2, 4, 8.
REQ-002 Parameter NONCE_W, default 32, nonce width in bits.
REQ-003 Parameter HASH_W, default 256, width of the hash and target in bits.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse; launches a search; honoured only in IDLE or DONE.
REQ-007 abort  input  1  level; returns the block to IDLE from any state.
REQ-008 nonce_base  input  NONCE_W  first nonce of the search; sampled on the accepted start.
REQ-009 target  input  HASH_W  difficulty target; sampled on the accepted start.
REQ-010 core_begin  output  NUM_CORES  per-core one-cycle launch pulse.
REQ-011 core_nonce  output  NUM_CORES*NONCE_W  per-core nonce, core i in slice [i*NONCE_W +: NONCE_W]; stable from launch until that core's done.
REQ-012 core_done  input  NUM_CORES  per-core one-cycle completion pulse.
REQ-013 core_hash  input  NUM_CORES*HASH_W  per-core result, valid in the cycle core_done[i]=1.
REQ-014 busy  output  1  high in LAUNCH and RUN.
REQ-015 complete  output  1  high in DONE.
REQ-016 found  output  1  high in DONE when a valid nonce was found.
REQ-017 found_nonce  output  NONCE_W  winning nonce; valid when found=1.
REQ-018 hash_count  output  32  number of core_done pulses accepted since the last accepted start; saturates at 0xFFFFFFFF.

Function
REQ-019 States: IDLE, LAUNCH, RUN, DONE.
REQ-020 IDLE/DONE + start (abort=0) -> LAUNCH: latch nonce_base and target; set core i nonce = nonce_base + i (mod 2^NONCE_W); clear found, found_nonce, hash_count, per-core retired flags.
REQ-021 A core whose initial nonce wrapped past 2^NONCE_W-1 is marked retired at launch and is never pulsed.
REQ-022 LAUNCH lasts exactly one cycle and asserts core_begin[i] for every non-retired core, then moves to RUN.
REQ-023 RUN, core_done[i]=1: the hash is valid when core_hash slice i <= latched target (unsigned, full HASH_W).
REQ-024 Valid hash: next state DONE, found=1, found_nonce = core i's current nonce.
REQ-025 Simultaneous valid hashes: the lowest core index wins.
REQ-026 Invalid hash, nonce+NUM_CORES <= 2^NONCE_W-1: core nonce += NUM_CORES, and core_begin[i] is pulsed the next cycle.
REQ-027 Invalid hash where the add would wrap: the core is retired and receives no further pulses.
REQ-028 RUN with all cores retired and no valid hash this cycle -> DONE, found=0.
REQ-029 In the cycle that enters DONE, no core_begin is asserted.
REQ-030 core_done pulses arriving in DONE or IDLE are ignored and not counted.
REQ-031 core_done for a retired or not-launched core is ignored.
REQ-032 hash_count increments once per accepted core_done bit; several bits in one cycle add their popcount.
REQ-033 DONE holds complete, found and found_nonce until the next accepted start or abort.
REQ-034 abort has priority over start and core_done: next state IDLE; core_begin=0; busy, complete and found cleared; hash_count retained.
REQ-035 start in LAUNCH or RUN is ignored.
REQ-036 Nonce arithmetic is unsigned, NONCE_W bits; the wrap check uses a NONCE_W+1-bit sum.

Reset
REQ-037 rst=1 at a clock edge forces IDLE in every state, including mid-RUN.
REQ-038 Reset values: core_begin=0, core_nonce=0, busy=0, complete=0, found=0, found_nonce=0, hash_count=0, and all per-core state cleared.
REQ-039 rst has priority over abort and start.

Verification
REQ-040 NUM_CORES=4, nonce_base=0x10, target=all-ones, start -> LAUNCH pulses all 4 cores with nonces 0x10-0x13; first done on core 2 -> found=1, found_nonce=0x12, complete=1.
REQ-041 target=0, cores return nonzero hashes, nonce_base=0xFFFFFFF8 -> each core gets exactly 2 launches; complete=1, found=0, hash_count=8.
REQ-042 Cores 1 and 3 both valid in the same cycle -> found_nonce = core 1's nonce.
REQ-043 abort asserted mid-RUN -> IDLE next cycle, busy=0, later core_done ignored, hash_count unchanged; a following start relaunches normally.
REQ-044 rst asserted mid-RUN, with core_done arriving during reset -> all outputs at reset values; no core_begin until a new start.
REQ-045 NUM_CORES=1, nonce_base=0xFFFFFFFF, target=0 -> one launch, then complete=1, found=0, hash_count=1.

Source files
------------

// File: rtl/multi_core_miner_ctrl_if.sv
// Bundle of host-side and SHA-core-side signals for the multi-core miner controller.
// The master side drives the search request and core results; the slave side is the controller.
interface multi_core_miner_ctrl_if #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 32,
    parameter int HASH_W    = 256
);
    logic                           start;
    logic                           abort;
    logic [NONCE_W-1:0]             nonce_base;
    logic [HASH_W-1:0]              target;
    logic [NUM_CORES-1:0]           core_begin;
    logic [NUM_CORES*NONCE_W-1:0]   core_nonce;
    logic [NUM_CORES-1:0]           core_done;
    logic [NUM_CORES*HASH_W-1:0]    core_hash;
    logic                           busy;
    logic                           complete;
    logic                           found;
    logic [NONCE_W-1:0]             found_nonce;
    logic [31:0]                    hash_count;

    modport master (
        output start, abort, nonce_base, target, core_done, core_hash,
        input  core_begin, core_nonce, busy, complete, found, found_nonce, hash_count
    );

    modport slave (
        input  start, abort, nonce_base, target, core_done, core_hash,
        output core_begin, core_nonce, busy, complete, found, found_nonce, hash_count
    );
endinterface

// File: rtl/multi_core_miner_ctrl.sv
// Nonce-search controller: hands interleaved nonces to NUM_CORES SHA cores, relaunches
// each core on a miss, and stops on the first hash at or below the target.
module multi_core_miner_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 32,
    parameter int HASH_W    = 256
) (
    input logic                      clk,
    input logic                      rst,
    multi_core_miner_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [NONCE_W-1:0]   nonce_q [NUM_CORES];
    logic [NONCE_W-1:0]   nonce_d [NUM_CORES];
    logic [NUM_CORES-1:0] retired_q, retired_d;
    logic [NUM_CORES-1:0] relaunch_q, relaunch_d;
    logic [HASH_W-1:0]    target_q, target_d;
    logic                 found_q, found_d;
    logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
    logic [31:0]          hash_count_q, hash_count_d;

    logic                 start_ok;
    logic [NUM_CORES-1:0] accepted;
    logic [NUM_CORES-1:0] valid_vec;
    logic                 win_any;
    logic [NONCE_W-1:0]   win_nonce;
    logic [NONCE_W:0]     step_sum   [NUM_CORES];
    logic [NONCE_W:0]     launch_sum [NUM_CORES];

    function automatic logic [31:0] popcount(input logic [NUM_CORES-1:0] v);
        logic [31:0] cnt;
        cnt = '0;
        for (int k = 0; k < NUM_CORES; k++) cnt = cnt + 32'(v[k]);
        return cnt;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Done pulses only count in RUN, for live cores, and never alongside abort.
    always_comb begin
        start_ok  = ((state_q == IDLE) || (state_q == DONE)) && bus.start && !bus.abort;
        accepted  = ((state_q == RUN) && !bus.abort) ? (bus.core_done & ~retired_q) : '0;
        valid_vec = '0;
        win_any   = 1'b0;
        win_nonce = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            step_sum[i]   = {1'b0, nonce_q[i]} + (NONCE_W+1)'(NUM_CORES);
            launch_sum[i] = {1'b0, bus.nonce_base} + (NONCE_W+1)'(i);
            valid_vec[i]  = accepted[i] && (bus.core_hash[i*HASH_W +: HASH_W] <= target_q);
        end
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (valid_vec[i]) begin
                win_any   = 1'b1;
                win_nonce = nonce_q[i];
            end
        end
    end

    always_comb begin
        nonce_d       = nonce_q;
        retired_d     = retired_q;
        relaunch_d    = '0;
        target_d      = target_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        hash_count_d  = hash_count_q;
        if (start_ok) begin
            target_d      = bus.target;
            found_d       = 1'b0;
            found_nonce_d = '0;
            hash_count_d  = '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                nonce_d[i]   = launch_sum[i][NONCE_W-1:0];
                retired_d[i] = launch_sum[i][NONCE_W];
            end
        end else if (bus.abort) begin
            found_d = 1'b0;
        end else if (state_q == RUN) begin
            hash_count_d = sat_add(hash_count_q, popcount(accepted));
            if (win_any) begin
                found_d       = 1'b1;
                found_nonce_d = win_nonce;
            end else begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (accepted[i]) begin
                        if (step_sum[i][NONCE_W]) begin
                            retired_d[i] = 1'b1;
                        end else begin
                            nonce_d[i]    = step_sum[i][NONCE_W-1:0];
                            relaunch_d[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (bus.start) state_d = LAUNCH;
                LAUNCH:     state_d = RUN;
                RUN:        if (win_any || (&retired_d)) state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CORES; i++) nonce_q[i] <= '0;
            retired_q     <= '0;
            relaunch_q    <= '0;
            target_q      <= '0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            hash_count_q  <= '0;
        end else begin
            nonce_q       <= nonce_d;
            retired_q     <= retired_d;
            relaunch_q    <= relaunch_d;
            target_q      <= target_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            hash_count_q  <= hash_count_d;
        end
    end

    // Relaunch pulses are only honoured while still in RUN, so entering DONE emits none.
    always_comb begin
        bus.core_begin  = '0;
        bus.core_nonce  = '0;
        bus.busy        = (state_q == LAUNCH) || (state_q == RUN);
        bus.complete    = (state_q == DONE);
        bus.found       = found_q;
        bus.found_nonce = found_nonce_q;
        bus.hash_count  = hash_count_q;
        if (!bus.abort) begin
            if (state_q == LAUNCH)   bus.core_begin = ~retired_q;
            else if (state_q == RUN) bus.core_begin = relaunch_q;
        end
        for (int i = 0; i < NUM_CORES; i++) bus.core_nonce[i*NONCE_W +: NONCE_W] = nonce_q[i];
    end

endmodule

// File: tb/tb_multi_core_miner_ctrl.sv
// Directed bench for multi_core_miner_ctrl: a 4-core instance for most scenarios and a
// 1-core instance for the single-core wrap case.
module tb_multi_core_miner_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   tests_run = 0;
    int   failures  = 0;

    always #5 clk = ~clk;

    multi_core_miner_ctrl_if #(.NUM_CORES(4), .NONCE_W(32), .HASH_W(256)) b4 ();
    multi_core_miner_ctrl_if #(.NUM_CORES(1), .NONCE_W(32), .HASH_W(256)) b1 ();

    multi_core_miner_ctrl #(.NUM_CORES(4), .NONCE_W(32), .HASH_W(256)) u4 (.clk(clk), .rst(rst), .bus(b4));
    multi_core_miner_ctrl #(.NUM_CORES(1), .NONCE_W(32), .HASH_W(256)) u1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hash4(input int idx, input logic [255:0] val);
        b4.core_hash[idx*256 +: 256] = val;
    endtask

    task automatic start4(input logic [31:0] base, input logic [255:0] tgt);
        b4.nonce_base = base;
        b4.target     = tgt;
        b4.start      = 1'b1;
        tick();
        b4.start      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++; if (b4.core_begin !== 4'h0) begin failures++; $display("FAIL rst_core_begin got %h exp %h", b4.core_begin, 4'h0); end
        tests_run++; if (b4.core_nonce !== 128'h0) begin failures++; $display("FAIL rst_core_nonce got %h exp 0", b4.core_nonce); end
        tests_run++; if ({b4.busy, b4.complete, b4.found} !== 3'b000) begin failures++; $display("FAIL rst_flags got %b exp 000", {b4.busy, b4.complete, b4.found}); end
        tests_run++; if (b4.hash_count !== 32'h0) begin failures++; $display("FAIL rst_hash_count got %h exp 0", b4.hash_count); end
        tests_run++; if (b4.found_nonce !== 32'h0) begin failures++; $display("FAIL rst_found_nonce got %h exp 0", b4.found_nonce); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_found();
        start4(32'h10, {256{1'b1}});
        tests_run++; if (b4.core_begin !== 4'hF) begin failures++; $display("FAIL launch_begin got %h exp %h", b4.core_begin, 4'hF); end
        tests_run++; if (b4.core_nonce !== {32'h13, 32'h12, 32'h11, 32'h10}) begin failures++; $display("FAIL launch_nonce got %h", b4.core_nonce); end
        tests_run++; if (b4.busy !== 1'b1) begin failures++; $display("FAIL launch_busy got %b exp 1", b4.busy); end
        tick();
        tests_run++; if (b4.core_begin !== 4'h0) begin failures++; $display("FAIL run_begin got %h exp 0", b4.core_begin); end
        b4.core_done = 4'b0100;
        set_hash4(2, 256'h5);
        tick();
        b4.core_done = 4'b0000;
        tests_run++; if ({b4.complete, b4.found, b4.busy} !== 3'b110) begin failures++; $display("FAIL found_flags got %b exp 110", {b4.complete, b4.found, b4.busy}); end
        tests_run++; if (b4.found_nonce !== 32'h12) begin failures++; $display("FAIL found_nonce got %h exp %h", b4.found_nonce, 32'h12); end
        tests_run++; if (b4.hash_count !== 32'd1) begin failures++; $display("FAIL found_count got %0d exp 1", b4.hash_count); end
        tests_run++; if (b4.core_begin !== 4'h0) begin failures++; $display("FAIL done_begin got %h exp 0", b4.core_begin); end
        b4.core_done = 4'b0001;
        tick();
        b4.core_done = 4'b0000;
        tests_run++; if (b4.hash_count !== 32'd1) begin failures++; $display("FAIL done_ignore_count got %0d exp 1", b4.hash_count); end
        tests_run++; if ({b4.complete, b4.found} !== 2'b11) begin failures++; $display("FAIL done_hold got %b exp 11", {b4.complete, b4.found}); end
    endtask

    task automatic test_exhaust();
        for (int i = 0; i < 4; i++) set_hash4(i, 256'h1);
        start4(32'hFFFF_FFF8, 256'h0);
        tests_run++; if (b4.core_nonce !== {32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'hFFFF_FFF8}) begin failures++; $display("FAIL exh_launch_nonce got %h", b4.core_nonce); end
        tests_run++; if ({b4.found, b4.hash_count} !== 33'h0) begin failures++; $display("FAIL exh_cleared got %b/%0d exp 0/0", b4.found, b4.hash_count); end
        tick();
        b4.core_done = 4'b0011;
        tick();
        tests_run++; if (b4.core_begin !== 4'b0011) begin failures++; $display("FAIL exh_relaunch_lo got %b exp 0011", b4.core_begin); end
        tests_run++; if (b4.core_nonce[63:0] !== {32'hFFFF_FFFD, 32'hFFFF_FFFC}) begin failures++; $display("FAIL exh_nonce_lo got %h", b4.core_nonce[63:0]); end
        b4.core_done = 4'b1100;
        tick();
        tests_run++; if (b4.core_begin !== 4'b1100) begin failures++; $display("FAIL exh_relaunch_hi got %b exp 1100", b4.core_begin); end
        tests_run++; if (b4.core_nonce[127:64] !== {32'hFFFF_FFFF, 32'hFFFF_FFFE}) begin failures++; $display("FAIL exh_nonce_hi got %h", b4.core_nonce[127:64]); end
        tests_run++; if (b4.hash_count !== 32'd4) begin failures++; $display("FAIL exh_mid_count got %0d exp 4", b4.hash_count); end
        b4.core_done = 4'b1111;
        tick();
        b4.core_done = 4'b0000;
        tests_run++; if ({b4.complete, b4.found, b4.core_begin} !== 6'b10_0000) begin failures++; $display("FAIL exh_done got %b exp 100000", {b4.complete, b4.found, b4.core_begin}); end
        tests_run++; if (b4.hash_count !== 32'd8) begin failures++; $display("FAIL exh_count got %0d exp 8", b4.hash_count); end
    endtask

    task automatic test_launch_wrap();
        for (int i = 0; i < 4; i++) set_hash4(i, 256'h1);
        start4(32'hFFFF_FFFE, 256'h0);
        tests_run++; if (b4.core_begin !== 4'b0011) begin failures++; $display("FAIL wrap_launch_begin got %b exp 0011", b4.core_begin); end
        tick();
        b4.core_done = 4'b1111;
        tick();
        b4.core_done = 4'b0000;
        tests_run++; if (b4.hash_count !== 32'd2) begin failures++; $display("FAIL wrap_count got %0d exp 2", b4.hash_count); end
        tests_run++; if ({b4.complete, b4.found, b4.core_begin} !== 6'b10_0000) begin failures++; $display("FAIL wrap_done got %b exp 100000", {b4.complete, b4.found, b4.core_begin}); end
    endtask

    task automatic test_tie();
        start4(32'h20, 256'h100);
        tick();
        b4.core_done = 4'b0001;
        set_hash4(0, 256'h101);
        tick();
        tests_run++; if ({b4.complete, b4.core_begin} !== 5'b0_0001) begin failures++; $display("FAIL tie_miss got %b exp 00001", {b4.complete, b4.core_begin}); end
        tests_run++; if (b4.core_nonce[31:0] !== 32'h24) begin failures++; $display("FAIL tie_step_nonce got %h exp 24", b4.core_nonce[31:0]); end
        b4.core_done = 4'b1010;
        set_hash4(1, 256'h100);
        set_hash4(3, 256'h0);
        tick();
        b4.core_done = 4'b0000;
        tests_run++; if (b4.found_nonce !== 32'h21) begin failures++; $display("FAIL tie_found_nonce got %h exp 21", b4.found_nonce); end
        tests_run++; if ({b4.complete, b4.found} !== 2'b11) begin failures++; $display("FAIL tie_flags got %b exp 11", {b4.complete, b4.found}); end
        tests_run++; if (b4.hash_count !== 32'd3) begin failures++; $display("FAIL tie_count got %0d exp 3", b4.hash_count); end
    endtask

    task automatic test_abort();
        start4(32'h40, 256'h0);
        tick();
        b4.core_done = 4'b0001;
        set_hash4(0, 256'h1);
        tick();
        b4.core_done = 4'b0000;
        b4.abort = 1'b1;
        tick();
        b4.abort = 1'b0;
        tests_run++; if ({b4.busy, b4.complete, b4.found, b4.core_begin} !== 7'b0) begin failures++; $display("FAIL abort_idle got %b exp 0", {b4.busy, b4.complete, b4.found, b4.core_begin}); end
        tests_run++; if (b4.hash_count !== 32'd1) begin failures++; $display("FAIL abort_count got %0d exp 1", b4.hash_count); end
        b4.core_done = 4'b1111;
        for (int i = 0; i < 4; i++) set_hash4(i, 256'h0);
        tick();
        b4.core_done = 4'b0000;
        tests_run++; if ({b4.hash_count, b4.complete} !== {32'd1, 1'b0}) begin failures++; $display("FAIL abort_ignore got %0d/%b exp 1/0", b4.hash_count, b4.complete); end
        start4(32'h50, {256{1'b1}});
        tests_run++; if ({b4.core_begin, b4.core_nonce[31:0]} !== {4'hF, 32'h50}) begin failures++; $display("FAIL relaunch got %h/%h exp F/50", b4.core_begin, b4.core_nonce[31:0]); end
        tick();
        start4(32'h90, {256{1'b1}});
        tests_run++; if ({b4.busy, b4.core_nonce[31:0]} !== {1'b1, 32'h50}) begin failures++; $display("FAIL run_start_ignored got %b/%h exp 1/50", b4.busy, b4.core_nonce[31:0]); end
        b4.core_done = 4'b1000;
        tick();
        b4.core_done = 4'b0000;
        tests_run++; if (b4.found_nonce !== 32'h53) begin failures++; $display("FAIL relaunch_found got %h exp 53", b4.found_nonce); end
    endtask

    task automatic test_reset_mid_run();
        start4(32'h60, {256{1'b1}});
        tick();
        rst = 1'b1;
        b4.core_done = 4'b1111;
        tick();
        tick();
        rst = 1'b0;
        b4.core_done = 4'b0000;
        tests_run++; if ({b4.busy, b4.complete, b4.found, b4.core_begin} !== 7'b0) begin failures++; $display("FAIL rstrun_flags got %b exp 0", {b4.busy, b4.complete, b4.found, b4.core_begin}); end
        tests_run++; if ({b4.hash_count, b4.found_nonce} !== 64'h0) begin failures++; $display("FAIL rstrun_regs got %h/%h exp 0/0", b4.hash_count, b4.found_nonce); end
        tests_run++; if (b4.core_nonce !== 128'h0) begin failures++; $display("FAIL rstrun_nonce got %h exp 0", b4.core_nonce); end
        tick();
        tick();
        tests_run++; if ({b4.busy, b4.core_begin} !== 5'b0) begin failures++; $display("FAIL rstrun_quiet got %b exp 0", {b4.busy, b4.core_begin}); end
    endtask

    task automatic test_single();
        b1.nonce_base = 32'hFFFF_FFFF;
        b1.target     = 256'h0;
        b1.core_hash  = 256'h1;
        b1.start      = 1'b1;
        tick();
        b1.start      = 1'b0;
        tests_run++; if ({b1.core_begin, b1.core_nonce} !== {1'b1, 32'hFFFF_FFFF}) begin failures++; $display("FAIL single_launch got %b/%h exp 1/FFFFFFFF", b1.core_begin, b1.core_nonce); end
        tick();
        tests_run++; if (b1.core_begin !== 1'b0) begin failures++; $display("FAIL single_run_begin got %b exp 0", b1.core_begin); end
        b1.core_done = 1'b1;
        tick();
        b1.core_done = 1'b0;
        tests_run++; if ({b1.complete, b1.found, b1.core_begin} !== 3'b100) begin failures++; $display("FAIL single_done got %b exp 100", {b1.complete, b1.found, b1.core_begin}); end
        tests_run++; if (b1.hash_count !== 32'd1) begin failures++; $display("FAIL single_count got %0d exp 1", b1.hash_count); end
    endtask

    initial begin
        rst           = 1'b1;
        b4.start      = 1'b0;
        b4.abort      = 1'b0;
        b4.nonce_base = '0;
        b4.target     = '0;
        b4.core_done  = '0;
        b4.core_hash  = '0;
        b1.start      = 1'b0;
        b1.abort      = 1'b0;
        b1.nonce_base = '0;
        b1.target     = '0;
        b1.core_done  = '0;
        b1.core_hash  = '0;
        test_reset();
        test_found();
        test_exhaust();
        test_launch_wrap();
        test_tie();
        test_abort();
        test_reset_mid_run();
        test_single();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
